// File: rtl/bidi_shift_pkg.sv
// Shared constants for the bidirectional shift array and its step timer.
package bidi_shift_pkg;

  localparam int SR_WIDTH_DEF = 8;
  localparam int SR_DEPTH_DEF = 16;
  localparam int RPT_W_DEF    = 8;

  localparam logic DIR_RIGHT   = 1'b0;
  localparam logic DIR_LEFT    = 1'b1;
  localparam logic MODE_INPUT  = 1'b0;
  localparam logic MODE_ROTATE = 1'b1;

endpackage

// File: rtl/step_timer.sv
// Step request source: rising-edge detect on the manual shift input plus a
// free-running auto-step counter that ticks once every auto_period cycles.
module step_timer
  import bidi_shift_pkg::*;
#(
  parameter int RPT_W = RPT_W_DEF
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             shift,
  input  logic             auto_en,
  input  logic [RPT_W-1:0] auto_period,
  output logic             step_req
);

  logic             shift_dly_q, shift_dly_d;
  logic [RPT_W-1:0] cnt_q, cnt_d;
  logic [RPT_W-1:0] last_cnt;
  logic             auto_active;
  logic             auto_tick;
  logic             manual_edge;

  assign last_cnt    = auto_period - RPT_W'(1);
  assign auto_active = auto_en && (auto_period != '0);
  assign auto_tick   = auto_active && (cnt_q == last_cnt);
  assign manual_edge = shift && !shift_dly_q;
  assign step_req    = manual_edge || auto_tick;

  always_comb begin
    shift_dly_d = shift;
    cnt_d       = cnt_q + RPT_W'(1);
    // A count at or beyond the last slot wraps; only the exact match ticks.
    if (!auto_active || (cnt_q >= last_cnt)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      shift_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      shift_dly_q <= shift_dly_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: rtl/bidi_shift_array.sv
// Programmable pattern store: SR_DEPTH x SR_WIDTH array that shifts or rotates
// either way, with random-access write, registered tap and fill tracking.
module bidi_shift_array
  import bidi_shift_pkg::*;
#(
  parameter int  SR_WIDTH = SR_WIDTH_DEF,
  parameter int  SR_DEPTH = SR_DEPTH_DEF,
  parameter int  RPT_W    = RPT_W_DEF,
  localparam int IDX_W    = $clog2(SR_DEPTH)
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [SR_WIDTH-1:0] input_data,
  input  logic                direction,
  input  logic                shift,
  input  logic                input_rotate,
  input  logic                auto_en,
  input  logic [RPT_W-1:0]    auto_period,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_index,
  input  logic [IDX_W-1:0]    tap_index,
  output logic [SR_WIDTH-1:0] output_data,
  output logic [SR_WIDTH-1:0] tap_data,
  output logic [IDX_W:0]      fill_count,
  output logic                full,
  output logic                empty,
  output logic                step_pulse,
  output logic                write_drop
);

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(SR_DEPTH);

  logic [SR_WIDTH-1:0] sr_q [SR_DEPTH];
  logic [SR_WIDTH-1:0] sr_d [SR_DEPTH];
  logic [IDX_W:0]      fill_q, fill_d;
  logic [SR_WIDTH-1:0] tap_q, tap_d;
  logic                step_pulse_q, step_pulse_d;
  logic                write_drop_q, write_drop_d;
  logic                step_req;
  logic                wr_ok;
  logic                tap_ok;

  step_timer #(.RPT_W(RPT_W)) u_step_timer (
    .clk        (clk),
    .nreset     (nreset),
    .shift      (shift),
    .auto_en    (auto_en),
    .auto_period(auto_period),
    .step_req   (step_req)
  );

  assign wr_ok  = {1'b0, wr_index} < DEPTH_C;
  assign tap_ok = {1'b0, tap_index} < DEPTH_C;

  always_comb begin
    sr_d         = sr_q;
    fill_d       = fill_q;
    step_pulse_d = step_req;
    // A step always wins over a same-cycle write.
    write_drop_d = wr_en && (step_req || !wr_ok);
    tap_d        = tap_ok ? sr_q[tap_index] : '0;
    if (step_req) begin
      if (direction == DIR_RIGHT) begin
        for (int i = SR_DEPTH - 1; i >= 1; i--) sr_d[i] = sr_q[i-1];
        sr_d[0] = (input_rotate == MODE_ROTATE) ? sr_q[SR_DEPTH-1] : input_data;
      end else begin
        for (int i = 0; i <= SR_DEPTH - 2; i++) sr_d[i] = sr_q[i+1];
        sr_d[SR_DEPTH-1] = (input_rotate == MODE_ROTATE) ? sr_q[0] : input_data;
      end
      if ((input_rotate == MODE_INPUT) && (fill_q != DEPTH_C)) begin
        fill_d = fill_q + (IDX_W + 1)'(1);
      end
    end else if (wr_en && wr_ok) begin
      sr_d[wr_index] = input_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int i = 0; i < SR_DEPTH; i++) sr_q[i] <= '0;
      fill_q       <= '0;
      tap_q        <= '0;
      step_pulse_q <= 1'b0;
      write_drop_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      fill_q       <= fill_d;
      tap_q        <= tap_d;
      step_pulse_q <= step_pulse_d;
      write_drop_q <= write_drop_d;
    end
  end

  assign output_data = sr_q[SR_DEPTH-1];
  assign tap_data    = tap_q;
  assign fill_count  = fill_q;
  assign full        = (fill_q == DEPTH_C);
  assign empty       = (fill_q == '0);
  assign step_pulse  = step_pulse_q;
  assign write_drop  = write_drop_q;

endmodule

// File: doc/bidi_shift_array.md
Name: bidi_shift_array

Overview:
- Parametrised successor of the team's bidirectional shift register: an SR_DEPTH x SR_WIDTH register array that shifts in new data or rotates, left or right.
- Adds random-access write, a registered tap readback at any index, an auto-step timer, and fill tracking with full/empty flags.
- Sits between the input pins and the display/output logic as a programmable pattern store.

Parameters:
SR_WIDTH, 8, bits per stage
SR_DEPTH, 16, number of stages (>=2)
IDX_W, $clog2(SR_DEPTH), index width (localparam, derived)
RPT_W, 8, width of the auto-step period

Ports:
clk  in  1  clock, all state updates on the rising edge
nreset  in  1  synchronous reset, active low
input_data  in  SR_WIDTH  data shifted in or written
direction  in  1  0 = right (toward index SR_DEPTH-1), 1 = left (toward index 0)
shift  in  1  manual step request, acted on at its rising edge only
input_rotate  in  1  0 = shift input_data in, 1 = rotate the end stage around
auto_en  in  1  enables the auto-step timer
auto_period  in  RPT_W  auto-step interval in cycles; 0 disables auto-stepping
wr_en  in  1  write input_data to sr[wr_index]
wr_index  in  IDX_W  write address
tap_index  in  IDX_W  readback address
output_data  out  SR_WIDTH  always equals sr[SR_DEPTH-1]
tap_data  out  SR_WIDTH  registered copy of sr[tap_index]
fill_count  out  IDX_W+1  number of stages loaded by shift-in, saturating
full  out  1  fill_count == SR_DEPTH
empty  out  1  fill_count == 0
step_pulse  out  1  high for one cycle in each cycle where a step is applied
write_drop  out  1  high for one cycle when a write is discarded

Behaviour:
- Reset, checked on the rising clk edge while nreset=0:
  - all sr stages, shift_dly, the auto timer, fill_count, tap_data, step_pulse and write_drop are cleared to 0.
  - shift_dly clears to 0, so a shift input held high while nreset deasserts produces a step on the first active cycle.
  - A reset mid-operation discards any pending step or write.
- Manual step: manual_edge = shift & ~shift_dly, where shift_dly is the value of shift registered every cycle.
- Auto timer:
  - When auto_en=1 and auto_period!=0, the timer counts 0..auto_period-1, raises auto_tick in the cycle it holds auto_period-1, and then wraps to 0.
  - When auto_en=0 or auto_period=0, the timer is held at 0 and there are no ticks.
  - If auto_period changes below the current count, the timer wraps to 0 on the next cycle without a tick.
- Step request = manual_edge | auto_tick. A manual edge and a tick in the same cycle produce exactly one step.
- A step applies on the next rising edge; step_pulse is registered and high in the following cycle.
  - Right: sr[i] <= sr[i-1] for i=SR_DEPTH-1..1; sr[0] <= input_rotate ? sr[SR_DEPTH-1] : input_data.
  - Left: sr[i] <= sr[i+1] for i=0..SR_DEPTH-2; sr[SR_DEPTH-1] <= input_rotate ? sr[0] : input_data.
- fill_count:
  - increments by 1 on each shift-in step (input_rotate=0), saturating at SR_DEPTH;
  - is unchanged by rotate steps and by writes;
  - full and empty are decoded combinationally from it.
- Write: when wr_en=1 with no step in the same cycle, sr[wr_index] <= input_data.
  - If a step occurs in the same cycle, the step wins, the write is discarded, and write_drop=1 in the next cycle.
  - wr_index >= SR_DEPTH: the write is ignored, write_drop=1 in the next cycle.
- output_data is continuous from sr[SR_DEPTH-1], with no extra latency.
- tap_data <= sr[tap_index] every cycle, so it shows pre-update array contents with 1-cycle latency. tap_index >= SR_DEPTH gives tap_data = 0.

Decomposition:
- Shared package bidi_shift_pkg:
  - DIR_RIGHT=1'b0, DIR_LEFT=1'b1;
  - MODE_INPUT=1'b0, MODE_ROTATE=1'b1;
  - default SR_WIDTH, SR_DEPTH and RPT_W values.
- One sub-module, step_timer: rising-edge detector plus auto-period counter producing step_req. This lets the timer be verified in isolation.
- The array, write port, tap and fill logic stay in bidi_shift_array.

Test Plan:
- Reset, then right-shift 0x11,0x22,0x33 with input_rotate=0 -> sr[2:0]=0x11,0x22,0x33, fill_count=3, empty falls after the first step.
- Hold shift high for 10 cycles -> exactly one step_pulse. Toggle it 20 times with SR_DEPTH=16, input_rotate=0 -> fill_count saturates at 16, full=1.
- Load 0x01..0x10 into sr[0..15], then rotate left once -> output_data=0x01, sr[0]=0x02, fill_count unchanged.
- auto_en=1, auto_period=4 -> step_pulse every 4th cycle. auto_period=0 -> no pulses. A manual edge coinciding with a tick -> a single step.
- wr_en=1, wr_index=5 in the same cycle as a step -> write discarded, write_drop=1 for one cycle. wr_index=5 alone -> the tap at 5 shows the data 1 cycle after the write lands.
- Assert nreset=0 mid-stream with shift high -> all outputs 0. After release, the held-high shift produces one step.
